dcache_direct_mapped: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache behind the MEM stage.
//  CPU side binds to the cache_interface slave signals (addr/valid/write/wr_data/wr_size/rd_data/ready/miss).

---
 rtl/dcache_direct_mapped_pkg.sv | 17 +
 rtl/dcache_direct_mapped_if.sv | 38 +++
 rtl/dcache_direct_mapped_store_merge.sv | 36 +++
 rtl/dcache_direct_mapped.sv | 160 ++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_direct_mapped_pkg.sv
// Shared types for the direct-mapped data cache.
// Provides access-size and controller-state enums.
package dcache_direct_mapped_pkg;

    typedef enum logic [1:0] {
        WORD = 2'd0,
        HALF = 2'd1,
        BYTE = 2'd2
    } cache_access_size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_t;

endpackage

// File: rtl/dcache_direct_mapped_if.sv
// CPU request bus plus line-wide memory req/ack bus.
// slave = cache side, master = CPU/memory side.
interface dcache_direct_mapped_if #(
    parameter int LINE_W = 128
) ();
    import dcache_direct_mapped_pkg::*;

    logic               valid;
    logic [31:0]        addr;
    logic               write;
    logic [31:0]        wr_data;
    cache_access_size_t wr_size;
    logic [31:0]        rd_data;
    logic               ready;
    logic               miss;

    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [LINE_W-1:0]  mem_wr_data;
    logic [LINE_W-1:0]  mem_rd_data;
    logic               mem_ack;

    modport slave (
        input  valid, addr, write, wr_data, wr_size,
        input  mem_rd_data, mem_ack,
        output rd_data, ready, miss,
        output mem_req, mem_we, mem_addr, mem_wr_data
    );

    modport master (
        output valid, addr, write, wr_data, wr_size,
        output mem_rd_data, mem_ack,
        input  rd_data, ready, miss,
        input  mem_req, mem_we, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/dcache_direct_mapped_store_merge.sv
// Store lane steering: size + addr[1:0] + data -> byte mask, lane data.
// Ports: size, addr_lo, wr_data in; be, lane_data out.
module dcache_store_merge
    import dcache_direct_mapped_pkg::*;
(
    input  cache_access_size_t size,
    input  logic [1:0]         addr_lo,
    input  logic [31:0]        wr_data,
    output logic [3:0]         be,
    output logic [31:0]        lane_data
);

    always_comb begin
        be        = 4'b0000;
        lane_data = wr_data;
        unique case (1'b1)
            (size == BYTE): begin
                be        = 4'b0001 << addr_lo;
                lane_data = {4{wr_data[7:0]}};
            end
            (size == HALF): begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wr_data[15:0]}};
            end
            (size == WORD): begin
                be        = 4'b1111;
                lane_data = wr_data;
            end
            default: begin
                be        = 4'b0000;
                lane_data = wr_data;
            end
        endcase
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back write-allocate D-cache behind MEM.
// Ports: clk_i, reset_ni, bus (CPU req + line mem req/ack, slave).
module dcache_direct_mapped
    import dcache_direct_mapped_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_BYTES = 16
) (
    input logic                   clk_i,
    input logic                   reset_ni,
    dcache_direct_mapped_if.slave bus
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int BIT_W  = OFF_W + 3;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    cache_state_t      state_q;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [TAG_W-1:0]  miss_tag_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [LINE_W-1:0] mem_wr_q;

    logic              hit;
    logic              ready;
    logic              store_en;
    logic              fill_en;
    logic [OFF_W-1:0]  woff_b;
    logic [BIT_W-1:0]  rd_pos;
    logic [31:0]       cur_word;
    logic [3:0]        be;
    logic [31:0]       lane_data;
    logic [LINE_BYTES-1:0] line_be;
    logic [LINE_W-1:0]     line_wdata;

    assign off = bus.addr[OFF_W-1:0];
    assign idx = bus.addr[OFF_W +: IDX_W];
    assign tag = bus.addr[31 -: TAG_W];

    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign ready    = bus.valid && (state_q == IDLE) && hit;
    assign store_en = ready && bus.write;
    // Only REFILL consumes an ack; a stray ack in IDLE is dropped.
    assign fill_en  = (state_q == REFILL) && bus.mem_ack;

    // Byte offset of the addressed word within the line.
    assign woff_b   = off & ~OFF_W'(3);
    assign rd_pos   = {woff_b, 3'b000};
    assign cur_word = data_q[idx][rd_pos +: 32];

    assign bus.ready   = ready;
    assign bus.miss    = bus.valid && !ready;
    assign bus.rd_data = bus.valid
                       ? (cur_word >> {bus.addr[1:0], 3'b000})
                       : 32'd0;

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_q;

    dcache_store_merge u_merge (
        .size      (bus.wr_size),
        .addr_lo   (bus.addr[1:0]),
        .wr_data   (bus.wr_data),
        .be        (be),
        .lane_data (lane_data)
    );

    // Spread the 4-lane store across the whole line at the word slot.
    assign line_be    = LINE_BYTES'(be) << woff_b;
    assign line_wdata = {(LINE_BYTES / 4){lane_data}};

    // Tag/data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[miss_idx_q] <= bus.mem_rd_data;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (store_en) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (line_be[i]) begin
                    data_q[idx][8*i +: 8] <= line_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wr_q   <= '0;
        end else begin
            if (store_en) begin
                dirty_q[idx] <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.valid && !hit) begin
                        miss_idx_q <= idx;
                        miss_tag_q <= tag;
                        mem_req_q  <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q    <= WRITEBACK;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {tag_q[idx], idx,
                                           {OFF_W{1'b0}}};
                            mem_wr_q   <= data_q[idx];
                        end else begin
                            state_q    <= REFILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) begin
                        state_q    <= REFILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {miss_tag_q, miss_idx_q,
                                       {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        state_q             <= IDLE;
                        mem_req_q           <= 1'b0;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped.
// Drives CPU requests and plays the memory side by hand.
module tb_dcache_direct_mapped;
    import dcache_direct_mapped_pkg::*;

    localparam int LW = 128;

    localparam logic [LW-1:0] LINE_A = {32'h3333_3333, 32'h2222_2222,
                                        32'h1111_1111, 32'hDEAD_BEEF};
    localparam logic [LW-1:0] LINE_A_MOD = {32'hCAFE_F00D, 32'hBEEF_2222,
                                            32'h1111_1111, 32'hDEAD_AAEF};
    localparam logic [LW-1:0] LINE_B = {32'h4444_4444, 32'h5555_5555,
                                        32'h6666_6666, 32'hA5A5_0001};
    localparam logic [LW-1:0] LINE_C = {32'hC3, 32'hC2, 32'hC1,
                                        32'h0BAD_F00D};
    localparam logic [LW-1:0] LINE_D = {32'h4444_0003, 32'h4444_0002,
                                        32'h4444_0001, 32'h7777_0063};
    localparam logic [LW-1:0] LINE_D_MOD = {32'h4444_0003, 32'h4444_0002,
                                            32'h600D_CAFE, 32'h7777_0063};
    localparam logic [LW-1:0] LINE_E = {32'hE3, 32'hE2, 32'hE1,
                                        32'h8000_13F0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    dcache_direct_mapped_if #(.LINE_W(LW)) bus ();

    dcache_direct_mapped #(
        .NUM_LINES  (64),
        .LINE_BYTES (16)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a,
                       input cache_access_size_t s,
                       input logic [31:0] d);
        bus.valid   = 1'b1;
        bus.write   = w;
        bus.addr    = a;
        bus.wr_size = s;
        bus.wr_data = d;
        #1;
    endtask

    task automatic give_ack(input logic [LW-1:0] line);
        bus.mem_rd_data = line;
        bus.mem_ack     = 1'b1;
        tick();
        bus.mem_ack     = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL rst_req got=%b exp=0", bus.mem_req);
        else passed++;
        checks++;
        if (bus.mem_we !== 1'b0)
            $display("FAIL rst_we got=%b exp=0", bus.mem_we);
        else passed++;
        checks++;
        if (bus.mem_addr !== 32'h0)
            $display("FAIL rst_addr got=%h exp=0", bus.mem_addr);
        else passed++;
        checks++;
        if (bus.ready !== 1'b0)
            $display("FAIL rst_ready got=%b exp=0", bus.ready);
        else passed++;
        checks++;
        if (bus.miss !== 1'b0)
            $display("FAIL rst_miss got=%b exp=0", bus.miss);
        else passed++;
        checks++;
        if (bus.rd_data !== 32'h0)
            $display("FAIL rst_rdata got=%h exp=0", bus.rd_data);
        else passed++;
        rst_n = 1'b1;
        tick();
        // stray ack with nothing outstanding
        give_ack(LINE_B);
        tick();
        checks++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL stray_ack got=%b exp=0", bus.mem_req);
        else passed++;
    endtask

    task automatic test_cold_load;
        tick();
        req(1'b0, 32'h1000, WORD, 32'h0);
        checks++;
        if (bus.miss !== 1'b1 || bus.ready !== 1'b0)
            $display("FAIL cold_miss got=%b/%b exp=1/0",
                     bus.miss, bus.ready);
        else passed++;
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0)
            $display("FAIL cold_req got=%b/%b exp=1/0",
                     bus.mem_req, bus.mem_we);
        else passed++;
        checks++;
        if (bus.mem_addr !== 32'h1000)
            $display("FAIL cold_addr got=%h exp=1000", bus.mem_addr);
        else passed++;
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1000
            || bus.miss !== 1'b1)
            $display("FAIL cold_hold got=%b/%h/%b exp=1/1000/1",
                     bus.mem_req, bus.mem_addr, bus.miss);
        else passed++;
        tick();
        give_ack(LINE_A);
        checks++;
        if (bus.ready !== 1'b1)
            $display("FAIL cold_ready got=%b exp=1", bus.ready);
        else passed++;
        checks++;
        if (bus.rd_data !== 32'hDEAD_BEEF)
            $display("FAIL cold_rdata got=%h exp=deadbeef", bus.rd_data);
        else passed++;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.miss !== 1'b0)
            $display("FAIL cold_done got=%b/%b exp=0/0",
                     bus.mem_req, bus.miss);
        else passed++;
    endtask

    task automatic test_store_hit;
        tick();
        req(1'b1, 32'h1001, BYTE, 32'h0000_00AA);
        checks++;
        if (bus.ready !== 1'b1)
            $display("FAIL sb_ready got=%b exp=1", bus.ready);
        else passed++;
        tick();
        req(1'b0, 32'h1000, WORD, 32'h0);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'hDEAD_AAEF)
            $display("FAIL sb_read got=%b/%h exp=1/deadaaef",
                     bus.ready, bus.rd_data);
        else passed++;
        checks++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL sb_noreq got=%b exp=0", bus.mem_req);
        else passed++;
    endtask

    task automatic test_partial;
        tick();
        req(1'b0, 32'h1002, HALF, 32'h0);
        checks++;
        if (bus.rd_data !== 32'h0000_DEAD)
            $display("FAIL ld_half got=%h exp=0000dead", bus.rd_data);
        else passed++;
        tick();
        req(1'b0, 32'h1003, BYTE, 32'h0);
        checks++;
        if (bus.rd_data !== 32'h0000_00DE)
            $display("FAIL ld_byte got=%h exp=000000de", bus.rd_data);
        else passed++;
        tick();
        req(1'b0, 32'h1004, WORD, 32'h0);
        checks++;
        if (bus.rd_data !== 32'h1111_1111)
            $display("FAIL ld_word1 got=%h exp=11111111", bus.rd_data);
        else passed++;
        tick();
        req(1'b1, 32'h100B, HALF, 32'h1234_BEEF);
        tick();
        req(1'b0, 32'h1008, WORD, 32'h0);
        checks++;
        if (bus.rd_data !== 32'hBEEF_2222)
            $display("FAIL st_half got=%h exp=beef2222", bus.rd_data);
        else passed++;
        tick();
        req(1'b0, 32'h100A, HALF, 32'h0);
        checks++;
        if (bus.rd_data !== 32'h0000_BEEF)
            $display("FAIL ld_half2 got=%h exp=0000beef", bus.rd_data);
        else passed++;
        tick();
        req(1'b1, 32'h100E, WORD, 32'hCAFE_F00D);
        tick();
        req(1'b0, 32'h100C, WORD, 32'h0);
        checks++;
        if (bus.rd_data !== 32'hCAFE_F00D || bus.ready !== 1'b1)
            $display("FAIL st_word got=%h/%b exp=cafef00d/1",
                     bus.rd_data, bus.ready);
        else passed++;
    endtask

    task automatic test_dirty_conflict;
        tick();
        req(1'b0, 32'h2000, WORD, 32'h0);
        checks++;
        if (bus.miss !== 1'b1 || bus.ready !== 1'b0)
            $display("FAIL wb_miss got=%b/%b exp=1/0",
                     bus.miss, bus.ready);
        else passed++;
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1
            || bus.mem_addr !== 32'h1000)
            $display("FAIL wb_req got=%b/%b/%h exp=1/1/1000",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        else passed++;
        checks++;
        if (bus.mem_wr_data !== LINE_A_MOD)
            $display("FAIL wb_data got=%h exp=%h",
                     bus.mem_wr_data, LINE_A_MOD);
        else passed++;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_wr_data !== LINE_A_MOD)
            $display("FAIL wb_hold got=%b exp=1", bus.mem_we);
        else passed++;
        give_ack({LW{1'b0}});
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0
            || bus.mem_addr !== 32'h2000)
            $display("FAIL wb_refill got=%b/%b/%h exp=1/0/2000",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        else passed++;
        checks++;
        if (bus.miss !== 1'b1)
            $display("FAIL wb_stall got=%b exp=1", bus.miss);
        else passed++;
        tick();
        give_ack(LINE_B);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'hA5A5_0001)
            $display("FAIL wb_hit got=%b/%h exp=1/a5a50001",
                     bus.ready, bus.rd_data);
        else passed++;
        checks++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL wb_idle got=%b exp=0", bus.mem_req);
        else passed++;
    endtask

    task automatic test_clean_conflict;
        tick();
        req(1'b0, 32'h3000, WORD, 32'h0);
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0
            || bus.mem_addr !== 32'h3000)
            $display("FAIL cc_req got=%b/%b/%h exp=1/0/3000",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        else passed++;
        // CPU drops the request mid-miss; the fill still finishes
        bus.valid = 1'b0;
        #1;
        checks++;
        if (bus.miss !== 1'b0 || bus.rd_data !== 32'h0)
            $display("FAIL cc_drop got=%b/%h exp=0/0",
                     bus.miss, bus.rd_data);
        else passed++;
        tick();
        give_ack(LINE_C);
        checks++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL cc_done got=%b exp=0", bus.mem_req);
        else passed++;
        tick();
        req(1'b0, 32'h3000, WORD, 32'h0);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'h0BAD_F00D)
            $display("FAIL cc_hit got=%b/%h exp=1/0badf00d",
                     bus.ready, bus.rd_data);
        else passed++;
    endtask

    task automatic test_index_boundary;
        tick();
        req(1'b0, 32'h13F0, WORD, 32'h0);
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0
            || bus.mem_addr !== 32'h13F0)
            $display("FAIL top_req got=%b/%b/%h exp=1/0/13f0",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        else passed++;
        give_ack(LINE_D);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'h7777_0063)
            $display("FAIL top_hit got=%b/%h exp=1/77770063",
                     bus.ready, bus.rd_data);
        else passed++;
        tick();
        req(1'b1, 32'h13F4, WORD, 32'h600D_CAFE);
        tick();
        // differs from resident tag only in address bit 31
        req(1'b0, 32'h8000_13F0, WORD, 32'h0);
        checks++;
        if (bus.ready !== 1'b0 || bus.miss !== 1'b1)
            $display("FAIL top_tag got=%b/%b exp=0/1",
                     bus.ready, bus.miss);
        else passed++;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h13F0)
            $display("FAIL top_wb got=%b/%h exp=1/13f0",
                     bus.mem_we, bus.mem_addr);
        else passed++;
        checks++;
        if (bus.mem_wr_data !== LINE_D_MOD)
            $display("FAIL top_wbdata got=%h exp=%h",
                     bus.mem_wr_data, LINE_D_MOD);
        else passed++;
        give_ack({LW{1'b0}});
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h8000_13F0)
            $display("FAIL top_refill got=%b/%h exp=0/800013f0",
                     bus.mem_we, bus.mem_addr);
        else passed++;
        give_ack(LINE_E);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'h8000_13F0)
            $display("FAIL top_hit2 got=%b/%h exp=1/800013f0",
                     bus.ready, bus.rd_data);
        else passed++;
        tick();
        req(1'b0, 32'h3000, WORD, 32'h0);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'h0BAD_F00D)
            $display("FAIL idx0_kept got=%b/%h exp=1/0badf00d",
                     bus.ready, bus.rd_data);
        else passed++;
    endtask

    task automatic test_reset_mid_refill;
        tick();
        req(1'b0, 32'h2000, WORD, 32'h0);
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000)
            $display("FAIL mr_req got=%b/%h exp=1/2000",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0)
            $display("FAIL mr_async got=%b/%h exp=0/0",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        bus.valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req(1'b0, 32'h2000, WORD, 32'h0);
        checks++;
        if (bus.ready !== 1'b0 || bus.miss !== 1'b1)
            $display("FAIL mr_cold got=%b/%b exp=0/1",
                     bus.ready, bus.miss);
        else passed++;
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0
            || bus.mem_addr !== 32'h2000)
            $display("FAIL mr_req2 got=%b/%b/%h exp=1/0/2000",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        else passed++;
        give_ack(LINE_B);
        checks++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 32'hA5A5_0001)
            $display("FAIL mr_hit got=%b/%h exp=1/a5a50001",
                     bus.ready, bus.rd_data);
        else passed++;
        tick();
        bus.valid = 1'b0;
    endtask

    initial begin
        bus.valid       = 1'b0;
        bus.write       = 1'b0;
        bus.addr        = 32'h0;
        bus.wr_data     = 32'h0;
        bus.wr_size     = WORD;
        bus.mem_rd_data = '0;
        bus.mem_ack     = 1'b0;
        test_reset();
        test_cold_load();
        test_store_hit();
        test_partial();
        test_dirty_conflict();
        test_clean_conflict();
        test_index_boundary();
        test_reset_mid_refill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d",
                 passed, checks);
        $fatal(1);
    end

endmodule
